// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, feeds a registered valid/ready slot toward decode,
// redirects locally on jumps and from execute on beq/beqz, and halts on end of program or bad target.
module fetch_sequencer #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 20,
    parameter int unsigned PROG_LEN = 20,
    parameter logic [4:0]  OP_JUMP  = 5'b01001,
    parameter logic [4:0]  OP_BEQZ  = 5'b01010,
    parameter logic [4:0]  OP_BEQ   = 5'b01011
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [PC_W-1:0]    dec_pc,
    input  logic               br_valid,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic               busy,
    output logic               halted,
    output logic               range_err
);

    typedef enum logic [1:0] {StIdle, StFetch, StWaitBr, StHalt} state_e;

    // One extra bit so range checks happen before any PC_W-bit wrap.
    localparam logic [PC_W:0] ProgLenW = (PC_W + 1)'(PROG_LEN);

    state_e               state_q;
    logic [PC_W-1:0]      pc_q;
    logic                 dec_valid_q;
    logic [INSTR_W-1:0]   dec_instr_q;
    logic [PC_W-1:0]      dec_pc_q;
    logic                 range_err_q;

    logic                 slot_free;
    logic                 fetch;
    logic [4:0]           opcode;
    logic [PC_W:0]        pc_inc;
    logic                 jump_ok;
    logic                 br_ok;

    assign slot_free = !dec_valid_q || dec_ready;
    assign fetch     = (state_q == StFetch) && slot_free;
    assign opcode    = imem_instr[INSTR_W-1 -: 5];
    assign pc_inc    = {1'b0, pc_q} + 1'b1;
    assign jump_ok   = {1'b0, imem_instr[PC_W-1:0]} < ProgLenW;
    assign br_ok     = {1'b0, br_target} < ProgLenW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            dec_valid_q <= 1'b0;
            dec_instr_q <= '0;
            dec_pc_q    <= '0;
            range_err_q <= 1'b0;
        end else begin
            if (fetch) begin
                dec_valid_q <= 1'b1;
                dec_instr_q <= imem_instr;
                dec_pc_q    <= pc_q;
            end else if (dec_ready) begin
                dec_valid_q <= 1'b0;
            end

            case (state_q)
                StIdle, StHalt: begin
                    if (start) begin
                        pc_q        <= '0;
                        range_err_q <= 1'b0;
                        state_q     <= StFetch;
                    end
                end
                StFetch: begin
                    if (slot_free) begin
                        if (opcode == OP_JUMP) begin
                            if (jump_ok) begin
                                pc_q <= imem_instr[PC_W-1:0];
                            end else begin
                                range_err_q <= 1'b1;
                                state_q     <= StHalt;
                            end
                        end else if (opcode == OP_BEQ || opcode == OP_BEQZ) begin
                            pc_q    <= pc_inc[PC_W-1:0];
                            state_q <= StWaitBr;
                        end else if (pc_inc == ProgLenW) begin
                            state_q <= StHalt;
                        end else begin
                            pc_q <= pc_inc[PC_W-1:0];
                        end
                    end
                end
                StWaitBr: begin
                    // start is deliberately ignored here, even alongside br_valid.
                    if (br_valid) begin
                        if (br_taken) begin
                            if (br_ok) begin
                                pc_q    <= br_target;
                                state_q <= StFetch;
                            end else begin
                                range_err_q <= 1'b1;
                                state_q     <= StHalt;
                            end
                        end else if ({1'b0, pc_q} == ProgLenW) begin
                            state_q <= StHalt;
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign imem_pc   = pc_q;
    assign dec_valid = dec_valid_q;
    assign dec_instr = dec_instr_q;
    assign dec_pc    = dec_pc_q;
    assign range_err = range_err_q;
    assign busy      = (state_q == StFetch) || (state_q == StWaitBr);
    assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a bench-owned program ROM, a scoreboard of expected
// transfer PCs popped on each decode handshake, and per-scenario tasks with inline checks.
module tb_fetch_sequencer;

    localparam int PROG = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  imem_pc;
    logic [19:0] imem_instr;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [19:0] dec_instr;
    logic [7:0]  dec_pc;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [7:0]  br_target = '0;
    logic        busy;
    logic        halted;
    logic        range_err;

    logic [19:0] rom [PROG];
    int          exp_q[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    assign imem_instr = (imem_pc < 8'(PROG)) ? rom[imem_pc] : 20'h0;

    fetch_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_pc    (imem_pc),
        .imem_instr (imem_instr),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_instr  (dec_instr),
        .dec_pc     (dec_pc),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .busy       (busy),
        .halted     (halted),
        .range_err  (range_err)
    );

    // Scoreboard: every handshake must match the oldest expected PC and its ROM word.
    always @(negedge clk) begin
        if (rst_n && dec_valid && dec_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL transfer: got unexpected dec_pc=%0d, required none", dec_pc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (dec_pc !== 8'(e) || dec_instr !== rom[e]) begin
                    bad++;
                    $display("FAIL transfer: got pc=%0d instr=%h, required pc=%0d instr=%h",
                             dec_pc, dec_instr, e, rom[e]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_q.push_back(i);
    endtask

    // Waits (bounded) for the scoreboard to empty; reports how many entries remain.
    task automatic drain(output int left);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        left = exp_q.size();
        exp_q.delete();
    endtask

    task automatic resolve(input logic taken, input logic [7:0] tgt);
        br_valid  = 1'b1;
        br_taken  = taken;
        br_target = tgt;
        tick();
        br_valid  = 1'b0;
        br_taken  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        total++;
        if ({dec_valid, busy, halted, range_err} !== 4'b0 || imem_pc !== 8'd0 ||
            dec_pc !== 8'd0 || dec_instr !== 20'd0) begin
            bad++;
            $display("FAIL reset: got v=%b b=%b h=%b e=%b pc=%0d dpc=%0d di=%h, required all 0",
                     dec_valid, busy, halted, range_err, imem_pc, dec_pc, dec_instr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        int left;
        push_range(0, 16);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (dec_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start_lat1: got v=%b busy=%b, required v=0 busy=1", dec_valid, busy);
        end
        tick();
        total++;
        if (dec_valid !== 1'b1 || dec_pc !== 8'd0) begin
            bad++;
            $display("FAIL start_lat2: got v=%b pc=%0d, required v=1 pc=0", dec_valid, dec_pc);
        end
        drain(left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("FAIL stream_drain: got %0d left, required 0", left);
        end
        repeat (3) tick();
        total++;
        if (dec_valid !== 1'b0 || imem_pc !== 8'd17 || busy !== 1'b1 || halted !== 1'b0) begin
            bad++;
            $display("FAIL wait_br_idle: got v=%b pc=%0d busy=%b h=%b, required v=0 pc=17 busy=1 h=0",
                     dec_valid, imem_pc, busy, halted);
        end
    endtask

    task automatic test_branch_taken();
        int left;
        exp_q.push_back(18);
        exp_q.push_back(19);
        push_range(0, 4);
        resolve(1'b1, 8'd18);
        drain(left);
        dec_ready = 1'b0;
        total++;
        if (left !== 0) begin
            bad++;
            $display("FAIL taken_drain: got %0d left, required 0", left);
        end
    endtask

    task automatic test_stall();
        int left;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (dec_valid !== 1'b1 || dec_pc !== 8'd5 || dec_instr !== rom[5] || imem_pc !== 8'd6) begin
                bad++;
                $display("FAIL stall_hold: got v=%b dpc=%0d di=%h pc=%0d, required v=1 dpc=5 di=%h pc=6",
                         dec_valid, dec_pc, dec_instr, imem_pc, rom[5]);
            end
            tick();
        end
        push_range(5, 16);
        dec_ready = 1'b1;
        drain(left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("FAIL stall_resume: got %0d left, required 0", left);
        end
    endtask

    task automatic test_branch_not_taken();
        int left;
        exp_q.push_back(17);
        resolve(1'b0, 8'd3);
        drain(left);
        repeat (2) tick();
        total++;
        if (left !== 0 || dec_valid !== 1'b0 || imem_pc !== 8'd18 || busy !== 1'b1) begin
            bad++;
            $display("FAIL beq_wait: got left=%0d v=%b pc=%0d busy=%b, required 0 0 18 1",
                     left, dec_valid, imem_pc, busy);
        end
        exp_q.push_back(18);
        exp_q.push_back(19);
        push_range(0, 16);
        resolve(1'b0, 8'd3);
        resolve(1'b1, 8'd3);
        drain(left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("FAIL not_taken_stream: got %0d left, required 0", left);
        end
    endtask

    task automatic test_range();
        int left;
        start = 1'b1;
        resolve(1'b1, 8'd25);
        start = 1'b0;
        total++;
        if (halted !== 1'b1 || range_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL br_range: got h=%b e=%b busy=%b, required h=1 e=1 busy=0",
                     halted, range_err, busy);
        end
        repeat (3) tick();
        total++;
        if (dec_valid !== 1'b0 || imem_pc !== 8'd17) begin
            bad++;
            $display("FAIL halt_quiet: got v=%b pc=%0d, required v=0 pc=17", dec_valid, imem_pc);
        end
        push_range(0, 16);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (range_err !== 1'b0 || busy !== 1'b1 || imem_pc !== 8'd0) begin
            bad++;
            $display("FAIL restart: got e=%b busy=%b pc=%0d, required e=0 busy=1 pc=0",
                     range_err, busy, imem_pc);
        end
        drain(left);
        // Out-of-range jump: still forwarded to decode, then halt.
        rom[19] = {5'b01001, 7'd0, 8'd30};
        exp_q.push_back(19);
        resolve(1'b1, 8'd19);
        drain(left);
        total++;
        if (left !== 0 || halted !== 1'b1 || range_err !== 1'b1 || imem_pc !== 8'd19) begin
            bad++;
            $display("FAIL jump_range: got left=%0d h=%b e=%b pc=%0d, required 0 1 1 19",
                     left, halted, range_err, imem_pc);
        end
    endtask

    task automatic test_end_of_program();
        int left;
        rom[19] = {5'b00001, 15'h1234};
        push_range(0, 16);
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(left);
        exp_q.push_back(17);
        resolve(1'b0, 8'd0);
        drain(left);
        exp_q.push_back(18);
        exp_q.push_back(19);
        resolve(1'b0, 8'd0);
        drain(left);
        repeat (2) tick();
        total++;
        if (left !== 0 || halted !== 1'b1 || range_err !== 1'b0 || dec_valid !== 1'b0 ||
            imem_pc !== 8'd19) begin
            bad++;
            $display("FAIL end_prog: got left=%0d h=%b e=%b v=%b pc=%0d, required 0 1 0 0 19",
                     left, halted, range_err, dec_valid, imem_pc);
        end
    endtask

    task automatic test_async_reset();
        int left;
        push_range(0, 15);
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(left);
        dec_ready = 1'b0;
        total++;
        if (dec_valid !== 1'b1 || dec_pc !== 8'd16 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: got v=%b dpc=%0d busy=%b, required v=1 dpc=16 busy=1",
                     dec_valid, dec_pc, busy);
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (dec_valid !== 1'b0 || imem_pc !== 8'd0 || busy !== 1'b0 || dec_pc !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: got v=%b pc=%0d busy=%b dpc=%0d, required all 0",
                     dec_valid, imem_pc, busy, dec_pc);
        end
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        dec_ready = 1'b1;
        repeat (4) tick();
        total++;
        if (dec_valid !== 1'b0 || busy !== 1'b0 || imem_pc !== 8'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got v=%b busy=%b pc=%0d, required 0 0 0",
                     dec_valid, busy, imem_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < PROG; i++) rom[i] = {5'b00001, 15'(i * 613 + 7)};
        rom[16] = {5'b01010, 15'd16};
        rom[17] = {5'b01011, 15'd17};
        rom[19] = {5'b01001, 7'd0, 8'd0};
        test_reset();
        test_stream();
        test_branch_taken();
        test_stall();
        test_branch_not_taken();
        test_range();
        test_end_of_program();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
